// File: rtl/pipe_adder.sv
// Two-stage pipelined N-bit adder with valid/ready flow control.
// The low slice is added in stage 1, the high slice plus carry in stage 2.
module pipe_adder #(
  parameter int N     = 16,
  parameter int SPLIT = N / 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int HW = N - SPLIT;

  typedef struct packed {
    logic [SPLIT-1:0] lo;
    logic             c_mid;
    logic [HW-1:0]    a_hi;
    logic [HW-1:0]    b_hi;
    logic             sa;
    logic             sb;
  } s1_t;

  s1_t              s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic             s2_ready;
  logic             in_xfer;
  logic             s2_load;
  logic [SPLIT:0]   lo_sum;
  logic [HW:0]      hi_sum;
  logic             ovf_d;

  assign s2_ready  = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_ready;
  assign in_xfer   = in_valid && in_ready;
  assign s2_load   = s1_valid && s2_ready;
  assign out_valid = s2_valid;

  assign lo_sum = {1'b0, a[SPLIT-1:0]}
                + {1'b0, b[SPLIT-1:0]}
                + {{SPLIT{1'b0}}, cin};

  assign hi_sum = {1'b0, s1_q.a_hi}
                + {1'b0, s1_q.b_hi}
                + {{HW{1'b0}}, s1_q.c_mid};

  // Overflow: equal operand signs, result sign differs.
  assign ovf_d = (s1_q.sa == s1_q.sb)
              && (hi_sum[HW-1] != s1_q.sa);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_xfer) begin
        s1_q.lo    <= lo_sum[SPLIT-1:0];
        s1_q.c_mid <= lo_sum[SPLIT];
        s1_q.a_hi  <= a[N-1:SPLIT];
        s1_q.b_hi  <= b[N-1:SPLIT];
        s1_q.sa    <= a[N-1];
        s1_q.sb    <= b[N-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (s2_ready) begin
        s2_valid <= s1_valid;
      end
      if (s2_load) begin
        sum  <= {hi_sum[HW-1:0], s1_q.lo};
        cout <= hi_sum[HW];
        ovf  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: directed vectors, streaming,
// back-pressure, mid-stream reset and randomized traffic.
module tb_pipe_adder;
  localparam int N     = 16;
  localparam int SPLIT = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  res_t held;
  bit   hold_vld = 0;

  pipe_adder #(.N(N), .SPLIT(SPLIT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic res_t model(logic [N-1:0] x, logic [N-1:0] y,
                                 logic c);
    res_t r;
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    r.sum  = t[N-1:0];
    r.cout = t[N];
    r.ovf  = (x[N-1] == y[N-1]) && (r.sum[N-1] != x[N-1]);
    return r;
  endfunction

  // Monitor: pops on every output transfer, checks hold during stalls.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (hold_vld)
          chk("stall_hold", {15'd0, sum, cout, ovf}, {15'd0, held});
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("result", {15'd0, sum, cout, ovf}, {15'd0, e});
          end
          pop_cyc.push_back(cyc);
          hold_vld = 0;
        end else begin
          held     = {sum, cout, ovf};
          hold_vld = 1;
        end
      end else begin
        hold_vld = 0;
      end
    end
  end

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y,
                      input logic c, input res_t e, output int acc);
    bit done;
    done = 0;
    acc = -1;
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = c;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        acc = cyc;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int first;
    int nacc;
    int idx;
    logic [N-1:0] pa[3];
    logic [N-1:0] pb[3];
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         c;
    bit           pend;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed vectors with spec-given expectations
    send(16'h0000, 16'hFFFF, 1'b1, {16'h0000, 1'b1, 1'b0}, acc);
    idle();
    @(negedge clk);
    chk("latency_k1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_k2", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    send(16'h00FF, 16'h0001, 1'b0, {16'h0100, 1'b0, 1'b0}, acc);
    send(16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1}, acc);
    send(16'h8000, 16'h8000, 1'b0, {16'h0000, 1'b1, 1'b1}, acc);
    send(16'hFFFF, 16'hFFFF, 1'b1, {16'hFFFF, 1'b1, 1'b0}, acc);
    idle();
    wait_drain();

    // Streaming: 8 back-to-back transfers
    pop_cyc.delete();
    first = -1;
    for (int i = 0; i < 8; i++) begin
      x = N'($urandom);
      y = N'($urandom);
      c = 1'($urandom);
      send(x, y, c, model(x, y, c), acc);
      if (i == 0) first = acc;
    end
    idle();
    wait_drain();
    chk("stream_count", 32'(pop_cyc.size()), 32'd8);
    if (pop_cyc.size() == 8) begin
      chk("stream_first_lat", 32'(pop_cyc[0]), 32'(first + 2));
      for (int i = 1; i < 8; i++)
        chk("stream_consec", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
    end

    // Back-pressure: only two results fit
    pop_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      pa[i] = N'($urandom);
      pb[i] = N'($urandom);
    end
    out_ready = 1'b0;
    nacc = 0;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (idx < 3);
      a = pa[idx % 3];
      b = pb[idx % 3];
      cin = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(pa[idx], pb[idx], 1'b0));
        idx++;
        nacc++;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", 32'(nacc), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    send(pa[2], pb[2], 1'b0, model(pa[2], pb[2], 1'b0), acc);
    idle();
    wait_drain();
    chk("bp_drained", 32'(pop_cyc.size()), 32'd3);

    // Reset with two results in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x = N'($urandom) | 16'h0100;
      y = N'($urandom);
      send(x, y, 1'b0, model(x, y, 1'b0), acc);
    end
    idle();
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_sum", 32'(sum), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("no_stale", 32'(out_valid), 32'd0);
    send(16'h1234, 16'h1111, 1'b0, {16'h2345, 1'b0, 1'b0}, acc);
    idle();
    wait_drain();

    // Randomized traffic against the reference model
    pend = 0;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(3) != 0);
      if (!pend && ($urandom_range(3) != 0)) begin
        x = N'($urandom);
        y = N'($urandom);
        c = 1'($urandom);
        pend = 1;
      end
      in_valid = pend;
      if (pend) begin
        a = x;
        b = y;
        cin = c;
      end
      @(negedge clk);
      if (pend && in_ready) begin
        exp_q.push_back(model(x, y, c));
        pend = 0;
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle();
    wait_drain();
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
